ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
- PS/2 host-side receiver that deserialises raw keyboard frames from the PS/2 clock/data pins.
- Folds E0/F0/E1 prefixes into one event per key. Emits the key_strobe / key_code / key_pressed / key_extended event interface consumed by the Oric keyboard matrix block.
- Sits between the board PS/2 pins and the matrix block. Receive only: it never drives the PS/2 lines.

Parameters:
- FILTER_LEN, 8: consecutive identical clk_24 samples required before a filtered PS/2 line changes state.
- TIMEOUT_CYC, 48000: clk_24 cycles (2 ms) without a filtered ps2_clk falling edge that abort a partial frame.
- PAUSE_SKIP, 7: bytes discarded after an E1 prefix.

Ports:
- clk_24 in 1: system clock, 24 MHz.
- reset_n in 1: asynchronous, active-low reset.
- ps2_clk in 1: raw PS/2 clock pin, asynchronous.
- ps2_data in 1: raw PS/2 data pin, asynchronous.
- key_strobe out 1: one-cycle pulse when a complete key event is valid.
- key_code out 8: final scancode byte, prefixes stripped.
- key_pressed out 1: 1 = make, 0 = break (F0 seen).
- key_extended out 1: 1 if an E0 prefix preceded the code.
- rx_busy out 1: high from the start-bit edge until frame end or abort.
- frame_err out 1: one-cycle pulse on start, parity or stop error, or on timeout.

Behaviour:
- Reset values (async, reset_n=0): key_strobe=0, key_code=8'h00, key_pressed=0, key_extended=0, rx_busy=0, frame_err=0. Also clears all prefix flags, the skip counter, the bit counter, the timeout counter and the filter state. Filtered lines reset to 1 (idle).
- Line conditioning:
  - Each pin passes through a 2-flop synchroniser and then a saturating filter of FILTER_LEN samples.
  - The filtered output changes only after FILTER_LEN identical synchronised samples.
  - A falling edge of filtered ps2_clk (fall) is a 1-cycle internal event. Filtered ps2_data is sampled in the same cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0, go to DATA, bitcnt=0, rx_busy=1. On fall with data=1 (bad start), pulse frame_err and stay in IDLE.
  - DATA: on each fall, shift data into shreg bit bitcnt (LSB first). After bit 7, go to PARITY.
  - PARITY: on fall, latch par_ok = (^shreg ^ data)==1 (odd parity). Go to STOP.
  - STOP: on fall, return to IDLE and set rx_busy=0. If data=1 and par_ok, the byte is valid; otherwise pulse frame_err and discard the byte.
  - Timeout: in any non-IDLE state, the timeout counter increments every cycle and clears on each fall. At TIMEOUT_CYC it forces IDLE, pulses frame_err, sets rx_busy=0 and clears the prefix flags.
- Byte handling, valid byte in cycle N; outputs update in cycle N+1:
  - skip counter non-zero: decrement it, emit nothing.
  - E0: set ext_f, emit nothing.
  - F0: set brk_f, emit nothing.
  - E1: load skip counter with PAUSE_SKIP, clear both flags, emit nothing.
  - AA, FA, FE, EE, 00, FF (BAT, ACK, resend, echo, overrun): clear both flags, emit nothing.
  - Any other byte: key_strobe=1, key_code=byte, key_pressed=~brk_f, key_extended=ext_f; then clear both flags.
- Output timing:
  - key_strobe is high for exactly one cycle.
  - key_code, key_pressed and key_extended hold their last values until the next strobe.
- Error paths:
  - frame_err on a stop or parity failure also clears ext_f and brk_f.
  - The skip counter is preserved on errors and cleared only by reset.
- Back-to-back frames: the next start bit is accepted on the first fall after STOP. No minimum idle gap is required.
- Reset mid-frame: the partial frame is lost and the next frame decodes normally.

Decomposition:
- Package oric_ps2_pkg:
  - rx_state_t enum (IDLE, DATA, PARITY, STOP).
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ECHO=8'hEE, PS2_OVR0=8'h00, PS2_OVR1=8'hFF.
- Sub-module ps2_line_filter (synchroniser plus FILTER_LEN filter, parameterised). Instantiated twice, once for clock and once for data.

Test Plan:
- Make, 'A': frame 1C, parity 0 → one key_strobe; key_code=1C, key_pressed=1, key_extended=0; frame_err never asserts.
- Extended break, up-arrow: E0 F0 75 → exactly one strobe; key_code=75, key_pressed=0, key_extended=1; no strobe for the E0 or F0 bytes.
- Parity error then recovery: frame 1C with parity bit inverted → frame_err pulses, no strobe. A following correct 16 → strobe with code 16, pressed=1, extended=0.
- Timeout with stale prefix: E0, then a frame stopped after 4 data bits → after 48000 cycles frame_err=1, rx_busy=0. A following correct 12 → key_extended=0 (prefix cleared).
- Pause key: E1 14 77 E1 F0 14 F0 77, then 29 → no strobes during the Pause sequence; a single strobe with code 29, pressed=1.
- Glitch and reset: a 5-cycle low glitch on ps2_clk while idle → no state change. reset_n pulsed low mid-frame → all outputs 0 immediately; the next full frame 45 decodes correctly.

Source files
------------

// File: rtl/oric_ps2_pkg.sv
// Shared types and PS/2 byte constants for the scancode receiver.
// Also holds the classifier for status bytes that never reach the matrix.
package oric_ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_OVR0   = 8'h00;
   localparam logic [7:0] PS2_OVR1   = 8'hFF;

   // Keyboard status/handshake bytes: swallowed, and they cancel pending prefixes.
   function automatic logic is_status(input logic [7:0] b);
      return b inside {PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVR0, PS2_OVR1};
   endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 pin inputs and key-event outputs of the scancode receiver.
// master = receiver side, slave = pins driver / matrix consumer side.
interface ps2_scancode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_strobe;
   logic [7:0] key_code;
   logic       key_pressed;
   logic       key_extended;
   logic       rx_busy;
   logic       frame_err;

   modport master (
      input  ps2_clk, ps2_data,
      output key_strobe, key_code, key_pressed, key_extended, rx_busy, frame_err
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  key_strobe, key_code, key_pressed, key_extended, rx_busy, frame_err
   );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a debounce filter: the output only
// follows the line after FILTER_LEN consecutive identical samples.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_24,
   input  logic reset_n,
   input  logic line,
   output logic filt
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         sync <= 2'b11;
         cnt  <= '0;
         filt <= 1'b1;
      end else begin
         sync <= {sync[0], line};
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 host receiver: deserialises frames and folds E0/F0/E1 prefixes
// into a single make/break event per key for the Oric keyboard matrix.
module ps2_scancode_rx
   import oric_ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 48000,
   parameter int PAUSE_SKIP  = 7
) (
   input logic              clk_24,
   input logic              reset_n,
   ps2_scancode_rx_if.master bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int SW = $clog2(PAUSE_SKIP + 1);

   logic clk_f, data_f, clk_prev, fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_24(clk_24), .reset_n(reset_n), .line(bus.ps2_clk), .filt(clk_f)
   );
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk_24(clk_24), .reset_n(reset_n), .line(bus.ps2_data), .filt(data_f)
   );

   assign fall = clk_prev & ~clk_f;

   rx_state_t     state;
   logic [7:0]    shreg;
   logic [2:0]    bitcnt;
   logic          par_ok;
   logic [TW-1:0] to_cnt;
   logic [SW-1:0] skip_cnt;
   logic          ext_f, brk_f;
   logic          key_strobe_q, key_pressed_q, key_extended_q, rx_busy_q, frame_err_q;
   logic [7:0]    key_code_q;

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         clk_prev       <= 1'b1;
         state          <= IDLE;
         shreg          <= '0;
         bitcnt         <= '0;
         par_ok         <= 1'b0;
         to_cnt         <= '0;
         skip_cnt       <= '0;
         ext_f          <= 1'b0;
         brk_f          <= 1'b0;
         key_strobe_q   <= 1'b0;
         key_code_q     <= '0;
         key_pressed_q  <= 1'b0;
         key_extended_q <= 1'b0;
         rx_busy_q      <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         clk_prev <= clk_f;
         // NOTE: pulse outputs default low each cycle; a later <= in this block overrides.
         key_strobe_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state       <= IDLE;
            to_cnt      <= '0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b1;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
         end else begin
            to_cnt <= (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
            if (fall) begin
               case (state)
                  IDLE: begin
                     if (!data_f) begin
                        state     <= DATA;
                        bitcnt    <= '0;
                        rx_busy_q <= 1'b1;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                  end
                  DATA: begin
                     shreg[bitcnt] <= data_f;
                     bitcnt        <= bitcnt + 1'b1;
                     if (bitcnt == 3'd7) state <= PARITY;
                  end
                  PARITY: begin
                     par_ok <= ^shreg ^ data_f;
                     state  <= STOP;
                  end
                  STOP: begin
                     state     <= IDLE;
                     rx_busy_q <= 1'b0;
                     if (!(data_f && par_ok)) begin
                        frame_err_q <= 1'b1;
                        ext_f       <= 1'b0;
                        brk_f       <= 1'b0;
                     end else if (skip_cnt != '0) begin
                        skip_cnt <= skip_cnt - 1'b1;
                     end else if (shreg == PS2_EXT) begin
                        ext_f <= 1'b1;
                     end else if (shreg == PS2_BRK) begin
                        brk_f <= 1'b1;
                     end else if (shreg == PS2_PAUSE) begin
                        skip_cnt <= SW'(PAUSE_SKIP);
                        ext_f    <= 1'b0;
                        brk_f    <= 1'b0;
                     end else begin
                        if (!is_status(shreg)) begin
                           key_strobe_q   <= 1'b1;
                           key_code_q     <= shreg;
                           key_pressed_q  <= ~brk_f;
                           key_extended_q <= ext_f;
                        end
                        ext_f <= 1'b0;
                        brk_f <= 1'b0;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign bus.key_strobe   = key_strobe_q;
   assign bus.key_code     = key_code_q;
   assign bus.key_pressed  = key_pressed_q;
   assign bus.key_extended = key_extended_q;
   assign bus.rx_busy      = rx_busy_q;
   assign bus.frame_err    = frame_err_q;

endmodule
